pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Detects load-use hazards that EX-stage forwarding cannot resolve.
- Kills wrong-path instructions after a taken branch or jump.
- Freezes the pipeline while the data memory inserts wait states.
- Drives the enable/clear controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and of the PC.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage core
// Optional performance counters when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int EXTRA_REDIRECT_FLUSH = 0,
    parameter int PERF_CNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [4:0]            decode_rd,
    input  logic [1:0]            decode_result_src,
    input  logic                  decode_regfile_wr_enable,
    input  logic                  execute_pc_src,
    input  logic                  mem_req,
    input  logic                  mem_ready,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_CNT_W-1:0] perf_stall_cycles,
    output logic [PERF_CNT_W-1:0] perf_flush_events,
`endif
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic                  flush_wb,
    output logic                  redirect_busy
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    localparam logic [2:0] RCNT_INIT = 3'(EXTRA_REDIRECT_FLUSH);

    state_t     state_q, state_d;
    logic [2:0] rcnt_q, rcnt_d;
    logic       lu_hit, mem_hold, redirect_acc;

    if (PERF_CNT_W < 1 || EXTRA_REDIRECT_FLUSH < 0 || EXTRA_REDIRECT_FLUSH > 7) begin : g_bad_param
    end

    assign lu_hit = (decode_result_src == 2'b01) && decode_regfile_wr_enable && (decode_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == decode_rd)) || (id_uses_rs2 && (id_rs2 == decode_rd)));
    assign mem_hold = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        stall_mem     = 1'b0;
        flush_id      = 1'b0;
        flush_ex      = 1'b0;
        flush_wb      = 1'b0;
        redirect_busy = 1'b0;
        redirect_acc  = 1'b0;
        if (!rst_n) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (mem_hold) begin
            // rcnt stays frozen so an interrupted redirect sequence resumes on release
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
            state_d   = MEM_WAIT;
        end else if (execute_pc_src) begin
            // the branch held in ID/EX during a wait is acted on in the release cycle
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            redirect_acc = 1'b1;
            rcnt_d       = RCNT_INIT;
            state_d      = (RCNT_INIT != 3'd0) ? REDIRECT : RUN;
        end else begin
            unique case (state_q)
                MEM_WAIT:   state_d = (rcnt_q != 3'd0) ? REDIRECT : RUN;
                LOAD_STALL: state_d = RUN;
                REDIRECT: begin
                    flush_id      = 1'b1;
                    redirect_busy = 1'b1;
                    if (rcnt_q <= 3'd1) begin
                        rcnt_d  = 3'd0;
                        state_d = RUN;
                    end else begin
                        rcnt_d = rcnt_q - 3'd1;
                    end
                end
                default: begin
                    if (lu_hit) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                        state_d  = LOAD_STALL;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_if)     perf_stall_q <= perf_stall_q + 1'b1;
            if (redirect_acc) perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_events = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed-vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int PCW = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, decode_rd;
    logic       id_uses_rs1, id_uses_rs2, decode_regfile_wr_enable;
    logic [1:0] decode_result_src;
    logic       execute_pc_src, mem_req, mem_ready;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_wb, redirect_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [PCW-1:0] perf_stall_cycles, perf_flush_events;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .EXTRA_REDIRECT_FLUSH(2),
        .PERF_CNT_W(PCW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .decode_rd(decode_rd),
        .decode_result_src(decode_result_src),
        .decode_regfile_wr_enable(decode_regfile_wr_enable),
        .execute_pc_src(execute_pc_src),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_events(perf_flush_events),
`endif
        .stall_if(stall_if),
        .stall_id(stall_id),
        .stall_ex(stall_ex),
        .stall_mem(stall_mem),
        .flush_id(flush_id),
        .flush_ex(flush_ex),
        .flush_wb(flush_wb),
        .redirect_busy(redirect_busy)
    );

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, redirect_busy}
    wire [7:0] outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, redirect_busy};

    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_RST   = 8'b0000_1100;
    localparam logic [7:0] O_LU    = 8'b1100_0100;
    localparam logic [7:0] O_REDIR = 8'b0000_1100;
    localparam logic [7:0] O_BUSY  = 8'b0000_1001;
    localparam logic [7:0] O_MEM   = 8'b1111_0010;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // inputs are already applied; check combinational outputs, then advance one clock
    task automatic cyc(input string tag, input logic [7:0] exp);
        #2;
        check(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        decode_rd = 5'd0; decode_result_src = 2'b00; decode_regfile_wr_enable = 1'b0;
        execute_pc_src = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        decode_result_src = 2'b01; decode_regfile_wr_enable = 1'b1; decode_rd = rd;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("reset_outs", {24'd0, outs}, {24'd0, O_RST});
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("idle", O_IDLE);

        set_load(5'd5); id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        cyc("lu_rs1_stall", O_LU);
        cyc("lu_rs1_release", O_IDLE);
        clear_inputs();
        cyc("lu_back_to_run", O_IDLE);

        set_load(5'd7); id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        cyc("lu_rs2_stall", O_LU);
        cyc("lu_rs2_release", O_IDLE);
        clear_inputs();

        set_load(5'd0); id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        cyc("load_x0_a", O_IDLE);
        cyc("load_x0_b", O_IDLE);
        decode_rd = 5'd5; id_rs1 = 5'd5; decode_result_src = 2'b00;
        cyc("alu_not_load", O_IDLE);
        decode_result_src = 2'b01; id_uses_rs1 = 1'b0;
        cyc("rs1_not_used", O_IDLE);
        clear_inputs();

        execute_pc_src = 1'b1;
        cyc("br_flush", O_REDIR);
        execute_pc_src = 1'b0;
        cyc("br_busy1", O_BUSY);
        cyc("br_busy2", O_BUSY);
        cyc("br_done", O_IDLE);

        mem_req = 1'b1; mem_ready = 1'b0;
        cyc("mw_1", O_MEM);
        execute_pc_src = 1'b1;
        cyc("mw_2_branch_held", O_MEM);
        cyc("mw_3_branch_held", O_MEM);
        mem_ready = 1'b1;
        cyc("mw_release_redirect", O_REDIR);
        clear_inputs();
        cyc("mw_busy1", O_BUSY);
        cyc("mw_busy2", O_BUSY);
        cyc("mw_done", O_IDLE);

        mem_req = 1'b1;
        cyc("mw_plain_hold", O_MEM);
        mem_ready = 1'b1;
        cyc("mw_plain_release", O_IDLE);
        clear_inputs();
        cyc("mw_plain_run", O_IDLE);

        execute_pc_src = 1'b1;
        cyc("mr_flush", O_REDIR);
        execute_pc_src = 1'b0;
        cyc("mr_busy_rcnt2", O_BUSY);
        mem_req = 1'b1;
        cyc("mr_hold", O_MEM);
        mem_ready = 1'b1;
        cyc("mr_release", O_IDLE);
        clear_inputs();
        cyc("mr_resume_busy", O_BUSY);
        cyc("mr_done", O_IDLE);

        set_load(5'd3); id_rs1 = 5'd3; id_uses_rs1 = 1'b1; execute_pc_src = 1'b1;
        cyc("br_beats_lu", O_REDIR);
        execute_pc_src = 1'b0;
        cyc("lu_ignored_redirect1", O_BUSY);
        cyc("lu_ignored_redirect2", O_BUSY);
        cyc("lu_after_redirect", O_LU);
        clear_inputs();
        cyc("lu_after_redirect_rel", O_IDLE);

        execute_pc_src = 1'b1;
        cyc("rst_mid_flush", O_REDIR);
        execute_pc_src = 1'b0;
        #2;
        check("rst_mid_in_redirect", {24'd0, outs}, {24'd0, O_BUSY});
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", {24'd0, outs}, {24'd0, O_RST});
`ifdef HAZARD_PERF_CNT_EN
        check("rst_perf_stall", {16'd0, perf_stall_cycles}, 32'd0);
        check("rst_perf_flush", {16'd0, perf_flush_events}, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("post_rst_run", O_IDLE);
        cyc("post_rst_run2", O_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
